// File: rtl/baseline_calib_ctrl.sv
// Baseline acquisition sequencer: averages 2^AVG_LOG2 samples per channel,
// channels 0..3 round-robin through one shared accumulator, with per-channel timeout.
module baseline_calib_ctrl #(
  parameter int DW          = 16,
  parameter int AVG_LOG2    = 6,
  parameter int TIMEOUT_CYC = 1000000,
  parameter int AUTO_START  = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cal_start,
  input  logic [4*DW-1:0] ch_data,
  input  logic [3:0]      ch_data_en,
  output logic [4*DW-1:0] ch_baseline,
  output logic [3:0]      baseline_vld,
  output logic            cal_busy,
  output logic            cal_done,
  output logic [3:0]      cal_err
);

  localparam int ACC_W = DW + AVG_LOG2;
  localparam logic [AVG_LOG2-1:0] CNT_LAST = {AVG_LOG2{1'b1}};
  localparam logic [AVG_LOG2-1:0] CNT_ONE  = AVG_LOG2'(1);
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYC - 1);
  localparam logic TMO_EN  = (TIMEOUT_CYC != 0);
  localparam logic AUTO_EN = (AUTO_START != 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACQ   = 2'd1,
    STORE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                  state_r, state_s;
  logic                    auto_pend_r, auto_pend_s;
  logic [ACC_W-1:0]        acc_r, acc_s;
  logic [AVG_LOG2-1:0]     cnt_r, cnt_s;
  logic [31:0]             tmo_r, tmo_s;
  logic [1:0]              ch_sel_r, ch_sel_s;
  logic [3:0][DW-1:0]      baseline_r, baseline_s;
  logic [3:0]              vld_r, vld_s;
  logic [3:0]              err_r, err_s;
  logic                    busy_r, busy_s;
  logic                    done_r, done_s;
  logic [3:0][DW-1:0]      data_s;
  logic                    strobe_s;

  assign data_s       = ch_data;
  assign strobe_s     = ch_data_en[ch_sel_r];
  assign ch_baseline  = baseline_r;
  assign baseline_vld = vld_r;
  assign cal_busy     = busy_r;
  assign cal_done     = done_r;
  assign cal_err      = err_r;

  // Next-state and datapath update for the calibration sequencer
  always_comb begin
    state_s     = state_r;
    auto_pend_s = auto_pend_r;
    acc_s       = acc_r;
    cnt_s       = cnt_r;
    tmo_s       = tmo_r;
    ch_sel_s    = ch_sel_r;
    baseline_s  = baseline_r;
    vld_s       = vld_r;
    err_s       = err_r;
    case (state_r)
      IDLE: begin
        if (cal_start || auto_pend_r) begin
          state_s     = ACQ;
          auto_pend_s = 1'b0;
          acc_s       = '0;
          cnt_s       = '0;
          tmo_s       = 32'd0;
          err_s       = 4'b0000;
          ch_sel_s    = 2'd0;
        end else begin
          state_s = IDLE;
        end
      end
      ACQ: begin
        if (strobe_s) begin
          acc_s = acc_r + ACC_W'(data_s[ch_sel_r]);
          cnt_s = cnt_r + CNT_ONE;
          tmo_s = 32'd0;
          if (cnt_r == CNT_LAST) begin
            state_s = STORE;
          end else begin
            state_s = ACQ;
          end
        end else if (TMO_EN && (tmo_r == TMO_LAST)) begin
          // Silent channel: flag it, keep its old baseline, move on as STORE would
          err_s[ch_sel_r] = 1'b1;
          if (ch_sel_r == 2'd3) begin
            state_s = DONE;
          end else begin
            ch_sel_s = ch_sel_r + 2'd1;
            acc_s    = '0;
            cnt_s    = '0;
            tmo_s    = 32'd0;
            state_s  = ACQ;
          end
        end else begin
          tmo_s = tmo_r + 32'd1;
        end
      end
      STORE: begin
        baseline_s[ch_sel_r] = acc_r[ACC_W-1:AVG_LOG2];
        vld_s[ch_sel_r]      = 1'b1;
        if (ch_sel_r == 2'd3) begin
          state_s = DONE;
        end else begin
          ch_sel_s = ch_sel_r + 2'd1;
          acc_s    = '0;
          cnt_s    = '0;
          tmo_s    = 32'd0;
          state_s  = ACQ;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    busy_s = (state_s == ACQ) || (state_s == STORE);
    done_s = (state_s == DONE);
  end

  // State and output registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= IDLE;
      auto_pend_r <= AUTO_EN;
      acc_r       <= '0;
      cnt_r       <= '0;
      tmo_r       <= 32'd0;
      ch_sel_r    <= 2'd0;
      baseline_r  <= '0;
      vld_r       <= 4'b0000;
      err_r       <= 4'b0000;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      auto_pend_r <= auto_pend_s;
      acc_r       <= acc_s;
      cnt_r       <= cnt_s;
      tmo_r       <= tmo_s;
      ch_sel_r    <= ch_sel_s;
      baseline_r  <= baseline_s;
      vld_r       <= vld_s;
      err_r       <= err_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
    end
  end

endmodule

// File: tb/tb_baseline_calib_ctrl.sv
// Scoreboard bench for baseline_calib_ctrl: expected pass results are queued at
// pass start and checked by a monitor on each cal_done pulse.
module tb_baseline_calib_ctrl;

  logic        clk;
  logic        rst;
  logic        cal_start;
  logic [63:0] a_data;
  logic [3:0]  a_en;
  logic [63:0] a_bl;
  logic [3:0]  a_vld;
  logic        a_busy;
  logic        a_done;
  logic [3:0]  a_err;

  logic        rst_b;
  logic        b_start;
  logic [63:0] b_data;
  logic [3:0]  b_en;
  logic [63:0] b_bl;
  logic [3:0]  b_vld;
  logic        b_busy;
  logic        b_done;
  logic [3:0]  b_err;

  typedef struct {
    logic [63:0] bl;
    logic [3:0]  vld;
    logic [3:0]  err;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   done_cnt = 0;
  logic arm_vld     = 1'b0;
  logic vld_drop    = 1'b0;
  logic b_ever_busy = 1'b0;

  baseline_calib_ctrl #(.DW(16), .AVG_LOG2(2), .TIMEOUT_CYC(20), .AUTO_START(1)) dut_a (
    .clk(clk), .rst(rst), .cal_start(cal_start), .ch_data(a_data), .ch_data_en(a_en),
    .ch_baseline(a_bl), .baseline_vld(a_vld), .cal_busy(a_busy), .cal_done(a_done),
    .cal_err(a_err)
  );

  baseline_calib_ctrl #(.DW(16), .AVG_LOG2(2), .TIMEOUT_CYC(20), .AUTO_START(0)) dut_b (
    .clk(clk), .rst(rst_b), .cal_start(b_start), .ch_data(b_data), .ch_data_en(b_en),
    .ch_baseline(b_bl), .baseline_vld(b_vld), .cal_busy(b_busy), .cal_done(b_done),
    .cal_err(b_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Scoreboard monitor: one queued expectation per cal_done pulse
  initial begin
    forever begin
      @(negedge clk);
      if (a_done === 1'b1) begin
        exp_t e;
        done_cnt++;
        if (q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: got cal_done=1, expected no pass pending");
        end else begin
          e = q.pop_front();
          check("pass_baselines", a_bl, e.bl);
          check("pass_vld", {60'd0, a_vld}, {60'd0, e.vld});
          check("pass_err", {60'd0, a_err}, {60'd0, e.err});
        end
      end
    end
  end

  // Sticky trackers: vld must never drop across a recal, B must never self-start
  always @(negedge clk) begin
    if (arm_vld && (a_vld !== 4'hF)) vld_drop <= 1'b1;
    if (rst_b && (b_busy !== 1'b0)) b_ever_busy <= 1'b1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic start_cal();
    @(negedge clk);
    cal_start = 1'b1;
    @(posedge clk);
    #1;
    cal_start = 1'b0;
  endtask

  // n samples on channel ch, then one idle cycle covering STORE
  task automatic feed(input int ch, input logic [15:0] d0, input logic [15:0] d1,
                      input logic [15:0] d2, input logic [15:0] d3, input int n,
                      input logic noise, input logic pulse);
    logic [15:0] d[4];
    d = '{d0, d1, d2, d3};
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      a_data = {16'hDEAD, 16'hBEEF, 16'hCAFE, 16'hF00D};
      a_data[ch*16 +: 16] = d[i];
      a_en = noise ? 4'hF : (4'b0001 << ch);
      cal_start = pulse && (i == 1);
    end
    @(negedge clk);
    a_en = 4'h0;
    cal_start = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_bl"}, a_bl, 64'd0);
    check({tag, "_vld"}, {60'd0, a_vld}, 64'd0);
    check({tag, "_busy"}, {63'd0, a_busy}, 64'd0);
    check({tag, "_done"}, {63'd0, a_done}, 64'd0);
    check({tag, "_err"}, {60'd0, a_err}, 64'd0);
  endtask

  initial begin
    rst = 1'b0; rst_b = 1'b0; cal_start = 1'b0;
    a_data = 64'd0; a_en = 4'h0;
    b_start = 1'b0; b_data = 64'd0; b_en = 4'h0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    check("b_reset_bl", b_bl, 64'd0);
    check("b_reset_busy", {63'd0, b_busy}, 64'd0);

    // Pass 1: auto-start, ch1 acquired under all-channel strobes
    q.push_back('{64'h1234_1234_1234_0067, 4'hF, 4'h0});
    rst = 1'b1; rst_b = 1'b1;
    feed(0, 16'd100, 16'd102, 16'd104, 16'd106, 4, 1'b0, 1'b0);
    feed(1, 16'h1234, 16'h1234, 16'h1234, 16'h1234, 4, 1'b1, 1'b0);
    feed(2, 16'h1234, 16'h1234, 16'h1234, 16'h1234, 4, 1'b0, 1'b0);
    check("mid_bl0", {48'd0, a_bl[15:0]}, 64'd103);
    check("mid_bl1", {48'd0, a_bl[31:16]}, 64'h1234);
    check("mid_bl3", {48'd0, a_bl[63:48]}, 64'd0);
    check("mid_vld", {60'd0, a_vld}, 64'h3);
    feed(3, 16'h1234, 16'h1234, 16'h1234, 16'h1234, 4, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    arm_vld = 1'b1;

    // Pass 2: full-scale, truncation, cal_start ignored during ACQ
    q.push_back('{64'h0008_0500_0001_FFFF, 4'hF, 4'h0});
    start_cal();
    feed(0, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 4, 1'b0, 1'b0);
    feed(1, 16'd1, 16'd1, 16'd1, 16'd2, 4, 1'b0, 1'b1);
    feed(2, 16'h0500, 16'h0500, 16'h0500, 16'h0500, 4, 1'b0, 1'b0);
    feed(3, 16'd7, 16'd8, 16'd9, 16'd10, 4, 1'b0, 1'b0);
    repeat (3) @(negedge clk);

    // Pass 3: ch2 silent, times out after 20 idle cycles
    q.push_back('{64'h0033_0500_0020_0010, 4'hF, 4'b0100});
    start_cal();
    feed(0, 16'h10, 16'h10, 16'h10, 16'h10, 4, 1'b0, 1'b0);
    feed(1, 16'h20, 16'h20, 16'h20, 16'h20, 4, 1'b0, 1'b0);
    repeat (20) @(negedge clk);
    feed(3, 16'h33, 16'h33, 16'h33, 16'h33, 4, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check("b_stays_idle", {63'd0, b_ever_busy}, 64'd0);

    // Pass 4: reset during ch1 ACQ, then auto-restart from ch0
    arm_vld = 1'b0;
    start_cal();
    feed(0, 16'h40, 16'h40, 16'h40, 16'h40, 4, 1'b0, 1'b0);
    feed(1, 16'h41, 16'h41, 16'h41, 16'h41, 2, 1'b0, 1'b0);
    rst = 1'b0;
    #1;
    check_zero("midpass_rst");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("restart_busy", {63'd0, a_busy}, 64'd1);
    q.push_back('{64'h0044_0033_0022_0011, 4'hF, 4'h0});
    feed(0, 16'h11, 16'h11, 16'h11, 16'h11, 4, 1'b0, 1'b0);
    feed(1, 16'h22, 16'h22, 16'h22, 16'h22, 4, 1'b0, 1'b0);
    feed(2, 16'h33, 16'h33, 16'h33, 16'h33, 4, 1'b0, 1'b0);
    feed(3, 16'h44, 16'h44, 16'h44, 16'h44, 4, 1'b0, 1'b0);
    repeat (5) @(negedge clk);

    check("done_count", 64'(done_cnt), 64'd4);
    check("queue_drained", 64'(q.size()), 64'd0);
    check("vld_never_dropped", {63'd0, vld_drop}, 64'd0);
    check("b_never_busy", {63'd0, b_ever_busy}, 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
